// File: rtl/mips_mem_arbiter_pkg.sv
// mips_mem_arbiter_pkg
//   Shared types for the instruction/data memory arbiter:
//   FSM state encoding, requester port IDs, counter width and the
//   word-alignment helper.
package mips_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_MA_IDLE   = 2'd0,
    S_MA_ACCESS = 2'd1,
    S_MA_RESP   = 2'd2
  } ma_state_t;

  typedef enum logic {
    MA_PORT_FETCH = 1'b0,
    MA_PORT_DATA  = 1'b1
  } ma_port_t;

  // Latency counter width; MEM_LATENCY is limited to 1..15.
  localparam int MA_CNT_W = 4;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mips_mem_arbiter_picker.sv
// mips_mem_arbiter_picker
//   Winner select between the fetch and data requesters.
//   Build option MIPS_MEM_ARB_RR_EN:
//     defined   - round-robin; last_grant register (resets to data, so
//                 fetch wins the first tie), updated on every handshake
//     undefined - fixed priority, data over fetch, no state
// Ports:
//   clk, rst, fire   - clock, sync active-high reset, handshake strobe
//                      (present only in the round-robin build)
//   f_valid, d_valid - requester valids
//   grant_data       - 1 = data port wins, 0 = fetch port wins
module mips_mem_arbiter_picker (
`ifdef MIPS_MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic fire,
`endif
  input  logic f_valid,
  input  logic d_valid,
  output logic grant_data
);
  import mips_mem_arbiter_pkg::*;

`ifdef MIPS_MEM_ARB_RR_EN
  ma_port_t last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= MA_PORT_DATA;
    end else if (fire) begin
      last_grant <= grant_data ? MA_PORT_DATA : MA_PORT_FETCH;
    end
  end

  always_comb begin
    grant_data = d_valid;
    // On a tie the port that was not granted last time wins.
    if (f_valid && d_valid) begin
      grant_data = (last_grant == MA_PORT_FETCH);
    end
  end
`else
  // Data wins whenever it is valid; fetch only gets the port when data is quiet.
  always_comb begin
    grant_data = d_valid;
  end
  logic unused_f_valid;
  assign unused_f_valid = f_valid;
`endif

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
//   Shares the single unified memory port between the multicycle core's
//   instruction-fetch and load/store requesters. One access is in flight
//   at a time; the address is held for MEM_LATENCY cycles and a one-cycle
//   response pulse is returned to the originating port. Misaligned
//   requests skip the memory cycle and respond with an error the next cycle.
//   Build option MIPS_MEM_ARB_RR_EN selects round-robin arbitration
//   (default: fixed priority, data over fetch).
// Parameters:
//   N           - address/data width
//   MEM_LATENCY - cycles from address presented to mem_rd_data valid (1..15)
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   f_req_*  / f_resp_*       - fetch request handshake and response
//   d_req_*  / d_resp_*       - load/store request handshake and response
//   mem_addr, mem_wr_data,
//   mem_wr_ena, mem_rd_data   - unified memory port
module mips_mem_arbiter #(
  parameter int N           = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         f_req_valid,
  output logic         f_req_ready,
  input  logic [N-1:0] f_req_addr,
  output logic         f_resp_valid,
  output logic [N-1:0] f_resp_data,
  output logic         f_resp_err,
  input  logic         d_req_valid,
  output logic         d_req_ready,
  input  logic [N-1:0] d_req_addr,
  input  logic         d_req_wr_ena,
  input  logic [N-1:0] d_req_wr_data,
  output logic         d_resp_valid,
  output logic [N-1:0] d_resp_data,
  output logic         d_resp_err,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wr_data,
  output logic         mem_wr_ena,
  input  logic [N-1:0] mem_rd_data
);
  import mips_mem_arbiter_pkg::*;

  localparam logic [MA_CNT_W-1:0] LAT_LOAD = MA_CNT_W'(MEM_LATENCY - 1);

  ma_state_t             state;
  logic [MA_CNT_W-1:0]   cnt;
  ma_port_t              port_q;
  logic                  wr_q;

  logic                  grant_data;
  logic                  idle;
  logic                  fire;
  logic [N-1:0]          sel_addr;
  logic                  sel_wr;
  logic                  sel_mis;

  assign idle = (state == S_MA_IDLE);

  // Ready is suppressed while rst is high so nothing is latched during reset.
  assign f_req_ready = !rst && idle && f_req_valid && !grant_data;
  assign d_req_ready = !rst && idle && d_req_valid &&  grant_data;
  assign fire        = f_req_ready || d_req_ready;

  assign sel_addr = grant_data ? d_req_addr : f_req_addr;
  assign sel_wr   = grant_data && d_req_wr_ena;   // fetch never writes
  assign sel_mis  = is_misaligned(sel_addr[1:0]);

  mips_mem_arbiter_picker u_picker (
`ifdef MIPS_MEM_ARB_RR_EN
    .clk        (clk),
    .rst        (rst),
    .fire       (fire),
`endif
    .f_valid    (f_req_valid),
    .d_valid    (d_req_valid),
    .grant_data (grant_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_MA_IDLE;
      cnt          <= '0;
      port_q       <= MA_PORT_FETCH;
      wr_q         <= 1'b0;
      mem_addr     <= '0;
      mem_wr_data  <= '0;
      mem_wr_ena   <= 1'b0;
      f_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      f_resp_err   <= 1'b0;
      d_resp_err   <= 1'b0;
    end else begin
      mem_wr_ena   <= 1'b0;
      f_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      f_resp_err   <= 1'b0;
      d_resp_err   <= 1'b0;
      case (state)
        S_MA_IDLE: begin
          if (fire) begin
            port_q <= grant_data ? MA_PORT_DATA : MA_PORT_FETCH;
            wr_q   <= sel_wr;
            if (sel_mis) begin
              // No memory cycle: mem_addr stays 0, straight to response.
              state        <= S_MA_RESP;
              f_resp_valid <= !grant_data;
              d_resp_valid <=  grant_data;
              f_resp_err   <= !grant_data;
              d_resp_err   <=  grant_data;
            end else begin
              state      <= S_MA_ACCESS;
              cnt        <= LAT_LOAD;
              mem_addr   <= sel_addr;
              mem_wr_ena <= sel_wr;
              if (sel_wr) begin
                mem_wr_data <= d_req_wr_data;
              end
            end
          end
        end
        S_MA_ACCESS: begin
          if (cnt == '0) begin
            state        <= S_MA_RESP;
            f_resp_valid <= (port_q == MA_PORT_FETCH);
            d_resp_valid <= (port_q == MA_PORT_DATA);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_MA_RESP: begin
          state    <= S_MA_IDLE;
          mem_addr <= '0;
        end
        default: begin
          state <= S_MA_IDLE;
        end
      endcase
    end
  end

  // Read data is passed straight through in the response cycle; stores and
  // errors return 0.
  assign f_resp_data = (f_resp_valid && !f_resp_err) ? mem_rd_data : '0;
  assign d_resp_data = (d_resp_valid && !d_resp_err && !wr_q) ? mem_rd_data : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
module tb_mips_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        preload;
  logic        sel;       // 0: latency-1 DUT, 1: latency-3 DUT
  logic        f_valid, d_valid, d_wr;
  logic [31:0] f_addr, d_addr, d_wdata;

  logic        f_valid_a, d_valid_a, f_valid_b, d_valid_b;
  assign f_valid_a = f_valid & ~sel;
  assign d_valid_a = d_valid & ~sel;
  assign f_valid_b = f_valid &  sel;
  assign d_valid_b = d_valid &  sel;

  logic        f_ready_a, f_rvalid_a, f_rerr_a, d_ready_a, d_rvalid_a, d_rerr_a, mwe_a;
  logic [31:0] f_rdata_a, d_rdata_a, maddr_a, mwdata_a, mrd_a;
  logic        f_ready_b, f_rvalid_b, f_rerr_b, d_ready_b, d_rvalid_b, d_rerr_b, mwe_b;
  logic [31:0] f_rdata_b, d_rdata_b, maddr_b, mwdata_b, mrd_b;

  mips_mem_arbiter #(.N(32), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst),
    .f_req_valid(f_valid_a), .f_req_ready(f_ready_a), .f_req_addr(f_addr),
    .f_resp_valid(f_rvalid_a), .f_resp_data(f_rdata_a), .f_resp_err(f_rerr_a),
    .d_req_valid(d_valid_a), .d_req_ready(d_ready_a), .d_req_addr(d_addr),
    .d_req_wr_ena(d_wr), .d_req_wr_data(d_wdata),
    .d_resp_valid(d_rvalid_a), .d_resp_data(d_rdata_a), .d_resp_err(d_rerr_a),
    .mem_addr(maddr_a), .mem_wr_data(mwdata_a), .mem_wr_ena(mwe_a), .mem_rd_data(mrd_a)
  );

  mips_mem_arbiter #(.N(32), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst),
    .f_req_valid(f_valid_b), .f_req_ready(f_ready_b), .f_req_addr(f_addr),
    .f_resp_valid(f_rvalid_b), .f_resp_data(f_rdata_b), .f_resp_err(f_rerr_b),
    .d_req_valid(d_valid_b), .d_req_ready(d_ready_b), .d_req_addr(d_addr),
    .d_req_wr_ena(d_wr), .d_req_wr_data(d_wdata),
    .d_resp_valid(d_rvalid_b), .d_resp_data(d_rdata_b), .d_resp_err(d_rerr_b),
    .mem_addr(maddr_b), .mem_wr_data(mwdata_b), .mem_wr_ena(mwe_b), .mem_rd_data(mrd_b)
  );

  // 16-word memory indexed by addr[5:2], shared; only one DUT is active at a time.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h2108000A;
      mem[2] <= 32'h8C090004;
      mem[3] <= 32'h12345678;
    end else begin
      if (mwe_a) mem[maddr_a[5:2]] <= mwdata_a;
      if (mwe_b) mem[maddr_b[5:2]] <= mwdata_b;
    end
  end
  assign mrd_a = mem[maddr_a[5:2]];
  assign mrd_b = mem[maddr_b[5:2]];

  logic        f_ready, f_rvalid, f_rerr, d_ready, d_rvalid, d_rerr, mwe;
  logic [31:0] f_rdata, d_rdata, maddr;
  always_comb begin
    if (sel) begin
      f_ready = f_ready_b; f_rvalid = f_rvalid_b; f_rerr = f_rerr_b; f_rdata = f_rdata_b;
      d_ready = d_ready_b; d_rvalid = d_rvalid_b; d_rerr = d_rerr_b; d_rdata = d_rdata_b;
      mwe = mwe_b; maddr = maddr_b;
    end else begin
      f_ready = f_ready_a; f_rvalid = f_rvalid_a; f_rerr = f_rerr_a; f_rdata = f_rdata_a;
      d_ready = d_ready_a; d_rvalid = d_rvalid_a; d_rerr = d_rerr_a; d_rdata = d_rdata_a;
      mwe = mwe_a; maddr = maddr_a;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        sel;
    logic        is_d;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_maddr;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic [31:0] data, maddr1;
    logic        err, other, timeout;
    int          lat, wcnt, w;
    data = '0; maddr1 = '0; err = 1'b0; other = 1'b0; timeout = 1'b0; lat = 0; wcnt = 0; w = 0;
    @(negedge clk);
    sel = v.sel;
    if (v.is_d) begin
      d_valid = 1'b1; d_addr = v.addr; d_wr = v.wr; d_wdata = v.wdata;
    end else begin
      f_valid = 1'b1; f_addr = v.addr;
    end
    #1;
    while (!(v.is_d ? d_ready : f_ready)) begin
      @(negedge clk); #1;
      w++;
      if (w > 20) begin
        timeout = 1'b1;
        break;
      end
    end
    if (!timeout) begin
      @(negedge clk);
      f_valid = 1'b0; d_valid = 1'b0; d_wr = 1'b0;
      for (int k = 1; k <= 30; k++) begin
        #1;
        if (mwe) wcnt++;
        if (k == 1) maddr1 = maddr;
        if (v.is_d ? f_rvalid : d_rvalid) other = 1'b1;
        if (v.is_d ? d_rvalid : f_rvalid) begin
          lat  = k;
          data = v.is_d ? d_rdata : f_rdata;
          err  = v.is_d ? d_rerr  : f_rerr;
          break;
        end
        @(negedge clk);
      end
      if (lat == 0) timeout = 1'b1;
    end
    f_valid = 1'b0; d_valid = 1'b0; d_wr = 1'b0;
    check({v.name, "_timeout"}, {31'b0, timeout}, 32'd0);
    check({v.name, "_data"},    data, v.exp_data);
    check({v.name, "_err"},     {31'b0, err}, {31'b0, v.exp_err});
    check({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({v.name, "_wr_cycles"}, 32'(wcnt), 32'(v.exp_wr));
    check({v.name, "_mem_addr"}, maddr1, v.exp_maddr);
    check({v.name, "_wrong_port"}, {31'b0, other}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string       seq, exp_seq;
    int          hs_cyc[$];
    logic        hs_port[$];
    int          resp_cnt, both_rdy, bad_resp, bad_gap, w;
    logic        found, tmo;

    rst = 1'b1; preload = 1'b1; sel = 1'b0;
    f_valid = 1'b0; d_valid = 1'b0; d_wr = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;

    //            name            sel  d   addr          wr  wdata         exp_data      err lat wr  maddr
    vecs[0]  = '{"fetch_l1",      0, 0, 32'h00400000, 0, 32'h0,        32'h2108000A, 0, 2, 0, 32'h00400000};
    vecs[1]  = '{"store_l1",      0, 1, 32'h10010004, 1, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'h10010004};
    vecs[2]  = '{"load_back_l1",  0, 1, 32'h10010004, 0, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h10010004};
    vecs[3]  = '{"load_misal",    0, 1, 32'h10010002, 0, 32'h0,        32'h0,        1, 1, 0, 32'h0};
    vecs[4]  = '{"fetch_misal",   0, 0, 32'h00400001, 0, 32'h0,        32'h0,        1, 1, 0, 32'h0};
    vecs[5]  = '{"store_misal",   0, 1, 32'h10010007, 1, 32'h55AA55AA, 32'h0,        1, 1, 0, 32'h0};
    vecs[6]  = '{"load_intact",   0, 1, 32'h10010004, 0, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h10010004};
    vecs[7]  = '{"fetch2_l1",     0, 0, 32'h00400008, 0, 32'h0,        32'h8C090004, 0, 2, 0, 32'h00400008};
    vecs[8]  = '{"fetch_l3",      1, 0, 32'h00400000, 0, 32'h0,        32'h2108000A, 0, 4, 0, 32'h00400000};
    vecs[9]  = '{"load_l3",       1, 1, 32'h1001000C, 0, 32'h0,        32'h12345678, 0, 4, 0, 32'h1001000C};
    vecs[10] = '{"store_l3",      1, 1, 32'h10010014, 1, 32'h0BADF00D, 32'h0,        0, 4, 1, 32'h10010014};
    vecs[11] = '{"load_back_l3",  1, 1, 32'h10010014, 0, 32'h0,        32'h0BADF00D, 0, 4, 0, 32'h10010014};

    repeat (3) @(negedge clk);
    preload = 1'b0;
    #1;
    check("rst_ctrl_a",   {25'b0, f_ready_a, d_ready_a, f_rvalid_a, d_rvalid_a, f_rerr_a, d_rerr_a, mwe_a}, 32'd0);
    check("rst_rdata_a",  f_rdata_a | d_rdata_a, 32'd0);
    check("rst_maddr_a",  maddr_a,  32'd0);
    check("rst_mwdata_a", mwdata_a, 32'd0);
    check("rst_ctrl_b",   {25'b0, f_ready_b, d_ready_b, f_rvalid_b, d_rvalid_b, f_rerr_b, d_rerr_b, mwe_b}, 32'd0);
    check("rst_rdata_b",  f_rdata_b | d_rdata_b, 32'd0);
    check("rst_maddr_b",  maddr_b,  32'd0);
    check("rst_mwdata_b", mwdata_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Both requesters valid every cycle on the latency-3 instance.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sel = 1'b1; f_addr = 32'h00400000; d_addr = 32'h1001000C; d_wr = 1'b0;
    f_valid = 1'b1; d_valid = 1'b1;
    seq = ""; resp_cnt = 0; both_rdy = 0; bad_resp = 0; bad_gap = 0;
    for (int i = 0; i < 22; i++) begin
      #1;
      if (f_ready && d_ready) both_rdy++;
      if (f_ready) begin seq = {seq, "F"}; hs_cyc.push_back(i); hs_port.push_back(1'b0); end
      if (d_ready) begin seq = {seq, "D"}; hs_cyc.push_back(i); hs_port.push_back(1'b1); end
      if (f_rvalid || d_rvalid) begin
        resp_cnt++;
        found = 1'b0;
        for (int j = 0; j < hs_cyc.size(); j++)
          if (hs_cyc[j] == i - 4 && hs_port[j] == d_rvalid) found = 1'b1;
        if (!found) bad_resp++;
      end
      @(negedge clk);
    end
    f_valid = 1'b0; d_valid = 1'b0;
    for (int j = 1; j < hs_cyc.size(); j++)
      if (hs_cyc[j] - hs_cyc[j-1] != 5) bad_gap++;
`ifdef MIPS_MEM_ARB_RR_EN
    exp_seq = "FDFDF";
`else
    exp_seq = "DDDDD";
`endif
    n_checks++;
    if (seq != exp_seq) begin
      n_fail++;
      $display("FAIL arb_grant_order: got %s, expected %s", seq, exp_seq);
    end
    check("arb_both_ready",  32'(both_rdy), 32'd0);
    check("arb_resp_count",  32'(resp_cnt), 32'd4);
    check("arb_resp_timing", 32'(bad_resp), 32'd0);
    check("arb_grant_gap",   32'(bad_gap),  32'd0);
    repeat (8) @(negedge clk);

    // Reset pulsed during ACCESS of a store on the latency-3 instance.
    sel = 1'b1; d_valid = 1'b1; d_addr = 32'h10010018; d_wr = 1'b1; d_wdata = 32'hCAFEF00D;
    #1;
    w = 0; tmo = 1'b0;
    while (!d_ready) begin
      @(negedge clk); #1;
      w++;
      if (w > 20) begin tmo = 1'b1; break; end
    end
    check("rstseq_handshake_timeout", {31'b0, tmo}, 32'd0);
    @(negedge clk);
    d_valid = 1'b0; d_wr = 1'b0;
    #1;
    check("rstseq_first_we", {31'b0, mwe}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rstseq_we_after_rst", {31'b0, mwe}, 32'd0);
    check("rstseq_maddr_after_rst", maddr, 32'd0);
    rst = 1'b0;
    resp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (f_rvalid || d_rvalid || mwe) resp_cnt++;
    end
    check("rstseq_no_resp", 32'(resp_cnt), 32'd0);
    run_vec('{"post_rst_fetch", 1, 0, 32'h00400000, 0, 32'h0, 32'h2108000A, 0, 4, 0, 32'h00400000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
